ex_stage: RTL and testbench

//  Consumer side of the ID/EX pipeline register: the execute stage plus the EX/MEM register of the RV64 5-stage core.

---
 rtl/ex_stage_if.sv | 63 ++++++
 rtl/ex_stage.sv | 144 ++++++++++++++
 tb/tb_ex_stage.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if
//   Bundle between the decode side, the write-back side and the EX/MEM
//   register of the execute stage.
//   - stall / flush    : EX/MEM update control
//   - id_*             : registered ID/EX instruction bundle
//   - wb_*             : MEM/WB write-back port, used for forwarding
//   - ex_*             : EX/MEM register contents
//   modport master : producer of id_*/wb_*/stall/flush, observer of ex_*
//   modport slave  : the execute stage itself
interface ex_stage_if #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
);
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rdata1;
    logic [XLEN-1:0] id_rdata2;
    logic [XLEN-1:0] id_imm;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [3:0]      id_funct;
    logic [1:0]      id_aluop;
    logic            id_branch;
    logic            id_memread;
    logic            id_memtoreg;
    logic            id_memwrite;
    logic            id_regwrite;
    logic            id_alusrc;
    logic            wb_regwrite;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic [XLEN-1:0] ex_alu;
    logic [XLEN-1:0] ex_wdata;
    logic [RA_W-1:0] ex_rd;
    logic            ex_memread;
    logic            ex_memtoreg;
    logic            ex_memwrite;
    logic            ex_regwrite;
    logic            ex_br_taken;
    logic [XLEN-1:0] ex_br_target;

    modport master (
        output stall, flush, id_valid, id_pc, id_rdata1, id_rdata2, id_imm,
               id_rs1, id_rs2, id_rd, id_funct, id_aluop, id_branch,
               id_memread, id_memtoreg, id_memwrite, id_regwrite, id_alusrc,
               wb_regwrite, wb_rd, wb_data,
        input  ex_valid, ex_alu, ex_wdata, ex_rd, ex_memread, ex_memtoreg,
               ex_memwrite, ex_regwrite, ex_br_taken, ex_br_target
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rdata1, id_rdata2, id_imm,
               id_rs1, id_rs2, id_rd, id_funct, id_aluop, id_branch,
               id_memread, id_memtoreg, id_memwrite, id_regwrite, id_alusrc,
               wb_regwrite, wb_rd, wb_data,
        output ex_valid, ex_alu, ex_wdata, ex_rd, ex_memread, ex_memtoreg,
               ex_memwrite, ex_regwrite, ex_br_taken, ex_br_target
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage
//   Execute stage of the RV64 5-stage core plus its EX/MEM register.
//   Forwards rs1/rs2 from EX/MEM (priority) or MEM/WB, runs the ALU,
//   resolves branches and registers everything into EX/MEM.
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-high; clears all EX/MEM state
//     bus   : ex_stage_if.slave (ID/EX bundle, MEM/WB port, EX/MEM outputs)
//   EX/MEM update priority per edge: reset > flush > stall > load.
module ex_stage #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  bus
);
    localparam int SH_W = $clog2(XLEN);

    logic            ex_valid_reg;
    logic [XLEN-1:0] ex_alu_reg;
    logic [XLEN-1:0] ex_wdata_reg;
    logic [RA_W-1:0] ex_rd_reg;
    logic            ex_memread_reg;
    logic            ex_memtoreg_reg;
    logic            ex_memwrite_reg;
    logic            ex_regwrite_reg;
    logic            ex_br_taken_reg;
    logic [XLEN-1:0] ex_br_target_reg;

    // A load in EX/MEM has no data yet, so it is never a forwarding source.
    logic ex_fwd_ok;
    logic wb_fwd_ok;
    assign ex_fwd_ok = ex_valid_reg & ex_regwrite_reg & ~ex_memread_reg
                     & (ex_rd_reg != '0);
    assign wb_fwd_ok = bus.wb_regwrite & (bus.wb_rd != '0);

    // Index 0 = rs1 (operand A), index 1 = rs2 (store data / operand B).
    logic [RA_W-1:0] src_addr [2];
    logic [XLEN-1:0] src_data [2];
    logic [XLEN-1:0] fwd_val  [2];

    assign src_addr[0] = bus.id_rs1;
    assign src_addr[1] = bus.id_rs2;
    assign src_data[0] = bus.id_rdata1;
    assign src_data[1] = bus.id_rdata2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_val[gi] = src_data[gi];
                if (ex_fwd_ok && (ex_rd_reg == src_addr[gi])) begin
                    fwd_val[gi] = ex_alu_reg;
                end else if (wb_fwd_ok && (bus.wb_rd == src_addr[gi])) begin
                    fwd_val[gi] = bus.wb_data;
                end
            end
        end
    endgenerate

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_next;
    logic            cond_next;
    logic [XLEN-1:0] target_next;

    assign op_a        = fwd_val[0];
    assign op_b        = bus.id_alusrc ? bus.id_imm : fwd_val[1];
    assign shamt       = op_b[SH_W-1:0];
    assign target_next = bus.id_pc + bus.id_imm;

    always_comb begin
        alu_next = op_a + op_b;
        unique case (bus.id_aluop)
            2'b01: alu_next = op_a - op_b;
            2'b10: begin
                case (bus.id_funct)
                    4'b1000: alu_next = op_a - op_b;
                    4'b0111: alu_next = op_a & op_b;
                    4'b0110: alu_next = op_a | op_b;
                    4'b0100: alu_next = op_a ^ op_b;
                    4'b0001: alu_next = op_a << shamt;
                    4'b0101: alu_next = op_a >> shamt;
                    4'b1101: alu_next = $unsigned($signed(op_a) >>> shamt);
                    default: alu_next = op_a + op_b;
                endcase
            end
            default: alu_next = op_a + op_b;
        endcase
    end

    always_comb begin
        cond_next = 1'b0;
        case (bus.id_funct[2:0])
            3'b000:  cond_next = (op_a == op_b);
            3'b001:  cond_next = (op_a != op_b);
            3'b100:  cond_next = ($signed(op_a) <  $signed(op_b));
            3'b101:  cond_next = ($signed(op_a) >= $signed(op_b));
            3'b110:  cond_next = (op_a <  op_b);
            3'b111:  cond_next = (op_a >= op_b);
            default: cond_next = 1'b0;
        endcase
    end

    // A load of an invalid ID/EX bundle is indistinguishable from a flush.
    always_ff @(posedge clk) begin
        if (reset || bus.flush || (!bus.stall && !bus.id_valid)) begin
            ex_valid_reg     <= 1'b0;
            ex_alu_reg       <= '0;
            ex_wdata_reg     <= '0;
            ex_rd_reg        <= '0;
            ex_memread_reg   <= 1'b0;
            ex_memtoreg_reg  <= 1'b0;
            ex_memwrite_reg  <= 1'b0;
            ex_regwrite_reg  <= 1'b0;
            ex_br_taken_reg  <= 1'b0;
            ex_br_target_reg <= '0;
        end else if (!bus.stall) begin
            ex_valid_reg     <= 1'b1;
            ex_alu_reg       <= alu_next;
            ex_wdata_reg     <= fwd_val[1];
            ex_rd_reg        <= bus.id_rd;
            ex_memread_reg   <= bus.id_memread;
            ex_memtoreg_reg  <= bus.id_memtoreg;
            ex_memwrite_reg  <= bus.id_memwrite;
            ex_regwrite_reg  <= bus.id_regwrite;
            ex_br_taken_reg  <= bus.id_branch & (bus.id_aluop == 2'b01) & cond_next;
            ex_br_target_reg <= target_next;
        end
    end

    assign bus.ex_valid     = ex_valid_reg;
    assign bus.ex_alu       = ex_alu_reg;
    assign bus.ex_wdata     = ex_wdata_reg;
    assign bus.ex_rd        = ex_rd_reg;
    assign bus.ex_memread   = ex_memread_reg;
    assign bus.ex_memtoreg  = ex_memtoreg_reg;
    assign bus.ex_memwrite  = ex_memwrite_reg;
    assign bus.ex_regwrite  = ex_regwrite_reg;
    assign bus.ex_br_taken  = ex_br_taken_reg;
    assign bus.ex_br_target = ex_br_target_reg;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
//   Directed vectors for ex_stage. Each vector pushes its hand-computed
//   EX/MEM snapshot into a scoreboard; a negedge monitor pops and compares.
module tb_ex_stage;
    logic clk;
    logic reset;

    ex_stage_if #(.XLEN(64), .RA_W(5)) ifc ();

    ex_stage #(.XLEN(64), .RA_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [3:0]  ctl;      // {memread, memtoreg, memwrite, regwrite}
        logic        taken;
        logic [63:0] target;
    } exp_t;

    // {branch, memread, memtoreg, memwrite, regwrite, alusrc}
    localparam logic [5:0] C_R  = 6'b000010;
    localparam logic [5:0] C_I  = 6'b000011;
    localparam logic [5:0] C_LD = 6'b011011;
    localparam logic [5:0] C_BR = 6'b100000;

    exp_t  sb_q   [$];
    string name_q [$];
    int    vectors     = 0;
    int    miscompares = 0;
    exp_t  zero_e;
    exp_t  held_e;

    function automatic exp_t mk(input logic v, input logic [63:0] alu,
                                input logic [63:0] wd, input logic [4:0] rd,
                                input logic [3:0] c, input logic tk,
                                input logic [63:0] tg);
        exp_t e;
        e.valid = v; e.alu = alu; e.wdata = wd; e.rd = rd;
        e.ctl = c; e.taken = tk; e.target = tg;
        return e;
    endfunction

    task automatic set_instr(input logic [63:0] pc, input logic [63:0] r1,
                             input logic [63:0] r2, input logic [63:0] imm,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [3:0] funct,
                             input logic [1:0] aluop, input logic [5:0] c);
        ifc.id_valid    = 1'b1;
        ifc.id_pc       = pc;
        ifc.id_rdata1   = r1;
        ifc.id_rdata2   = r2;
        ifc.id_imm      = imm;
        ifc.id_rs1      = rs1;
        ifc.id_rs2      = rs2;
        ifc.id_rd       = rd;
        ifc.id_funct    = funct;
        ifc.id_aluop    = aluop;
        ifc.id_branch   = c[5];
        ifc.id_memread  = c[4];
        ifc.id_memtoreg = c[3];
        ifc.id_memwrite = c[2];
        ifc.id_regwrite = c[1];
        ifc.id_alusrc   = c[0];
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [63:0] d);
        ifc.wb_regwrite = we;
        ifc.wb_rd       = rd;
        ifc.wb_data     = d;
    endtask

    // Clock the current inputs in, then queue what EX/MEM must show.
    task automatic step(input string nm, input exp_t e);
        @(posedge clk);
        #1;
        sb_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string nm;
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            g  = mk(ifc.ex_valid, ifc.ex_alu, ifc.ex_wdata, ifc.ex_rd,
                    {ifc.ex_memread, ifc.ex_memtoreg, ifc.ex_memwrite, ifc.ex_regwrite},
                    ifc.ex_br_taken, ifc.ex_br_target);
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL %s: got v=%0b alu=%h wd=%h rd=%0d ctl=%b tk=%0b tg=%h ; want v=%0b alu=%h wd=%h rd=%0d ctl=%b tk=%0b tg=%h",
                         nm, g.valid, g.alu, g.wdata, g.rd, g.ctl, g.taken, g.target,
                         e.valid, e.alu, e.wdata, e.rd, e.ctl, e.taken, e.target);
            end else begin
                $display("ok   %s: v=%0b alu=%h rd=%0d tk=%0b tg=%h",
                         nm, g.valid, g.alu, g.rd, g.taken, g.target);
            end
        end
    end

    initial begin
        zero_e = mk(1'b0, 64'd0, 64'd0, 5'd0, 4'b0000, 1'b0, 64'd0);

        // Reset wins over stall and flush, with a valid bundle present.
        reset = 1'b1; ifc.stall = 1'b1; ifc.flush = 1'b1;
        set_instr(64'h40, 64'd1, 64'd2, 64'd3, 5'd1, 5'd2, 5'd3, 4'h0, 2'b10, C_R);
        set_wb(1'b1, 5'd1, 64'd77);
        step("reset", zero_e);
        reset = 1'b0; ifc.stall = 1'b0; ifc.flush = 1'b0;

        // add x3,x1,x2
        set_wb(1'b0, 5'd0, 64'd0);
        set_instr(64'h0, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd3, 4'h0, 2'b10, C_R);
        step("add", mk(1'b1, 64'd12, 64'd7, 5'd3, 4'b0001, 1'b0, 64'h0));

        // sub x4,x3,x1: EX/MEM (12) beats MEM/WB (99)
        set_wb(1'b1, 5'd3, 64'd99);
        set_instr(64'h4, 64'd0, 64'd5, 64'd0, 5'd3, 5'd1, 5'd4, 4'h8, 2'b10, C_R);
        step("sub_fwd_ex", mk(1'b1, 64'd7, 64'd5, 5'd4, 4'b0001, 1'b0, 64'h4));

        // add x0,x4,x1: 7+5
        set_instr(64'h8, 64'd0, 64'd5, 64'd0, 5'd4, 5'd1, 5'd0, 4'h0, 2'b10, C_R);
        step("add_x0_dst", mk(1'b1, 64'd12, 64'd5, 5'd0, 4'b0001, 1'b0, 64'h8));

        // sub x6,x0,x0: EX/MEM and MEM/WB both target x0, no forwarding
        set_wb(1'b1, 5'd0, 64'd99);
        set_instr(64'hC, 64'd11, 64'd3, 64'd0, 5'd0, 5'd0, 5'd6, 4'h8, 2'b10, C_R);
        step("sub_x0_nofwd", mk(1'b1, 64'd8, 64'd3, 5'd6, 4'b0001, 1'b0, 64'hC));

        // ld x7,8(x0)
        set_wb(1'b0, 5'd0, 64'd0);
        set_instr(64'h10, 64'h1000, 64'd0, 64'd8, 5'd0, 5'd0, 5'd7, 4'h3, 2'b00, C_LD);
        step("load", mk(1'b1, 64'h1008, 64'd0, 5'd7, 4'b1101, 1'b0, 64'h18));

        // add x8,x7,x0: load in EX/MEM is not forwarded
        set_instr(64'h14, 64'd2, 64'd0, 64'd0, 5'd7, 5'd0, 5'd8, 4'h0, 2'b10, C_R);
        step("load_nofwd", mk(1'b1, 64'd2, 64'd0, 5'd8, 4'b0001, 1'b0, 64'h14));

        // add x9,x8,x5: A from EX/MEM (2), B from MEM/WB (100)
        set_wb(1'b1, 5'd5, 64'd100);
        set_instr(64'h18, 64'd0, 64'd0, 64'd0, 5'd8, 5'd5, 5'd9, 4'h0, 2'b10, C_R);
        step("fwd_ex_wb", mk(1'b1, 64'd102, 64'd100, 5'd9, 4'b0001, 1'b0, 64'h18));

        // beq taken
        set_wb(1'b0, 5'd0, 64'd0);
        set_instr(64'h100, 64'd9, 64'd9, 64'h20, 5'd10, 5'd11, 5'd0, 4'h0, 2'b01, C_BR);
        step("beq", mk(1'b1, 64'd0, 64'd9, 5'd0, 4'b0000, 1'b1, 64'h120));

        // blt -1 < 1 taken
        set_instr(64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8,
                  5'd10, 5'd11, 5'd0, 4'h4, 2'b01, C_BR);
        step("blt", mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 5'd0, 4'b0000, 1'b1, 64'h1F8));

        // bltu same operands not taken
        ifc.id_funct = 4'h6;
        step("bltu", mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 5'd0, 4'b0000, 1'b0, 64'h1F8));

        // sra by 63
        set_instr(64'h0, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 5'd12, 5'd13, 5'd14,
                  4'hD, 2'b10, C_I);
        step("sra", mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd14, 4'b0001, 1'b0, 64'd63));

        // srl by 63
        ifc.id_funct = 4'h5;
        step("srl", mk(1'b1, 64'd1, 64'd0, 5'd14, 4'b0001, 1'b0, 64'd63));

        // sll 1<<4
        set_instr(64'h0, 64'd1, 64'd0, 64'd4, 5'd12, 5'd13, 5'd16, 4'h1, 2'b10, C_I);
        step("sll", mk(1'b1, 64'd16, 64'd0, 5'd16, 4'b0001, 1'b0, 64'd4));

        // xor
        set_instr(64'h0, 64'hF0, 64'hFF, 64'd0, 5'd17, 5'd18, 5'd19, 4'h4, 2'b10, C_R);
        step("xor", mk(1'b1, 64'h0F, 64'hFF, 5'd19, 4'b0001, 1'b0, 64'd0));

        // or, then kept as the held value
        set_instr(64'h0, 64'h0C, 64'h03, 64'd0, 5'd20, 5'd21, 5'd15, 4'h6, 2'b10, C_R);
        held_e = mk(1'b1, 64'h0F, 64'h03, 5'd15, 4'b0001, 1'b0, 64'd0);
        step("or", held_e);

        // stall three cycles with changing inputs
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(64'h300 + 64'(i), 64'(i + 40), 64'(i + 3), 64'd4, 5'd22, 5'd23,
                      5'(i + 25), 4'h8, 2'b10, C_LD);
            set_wb(1'b1, 5'd22, 64'd55);
            step("stall_hold", held_e);
        end

        // stall and flush together -> bubble
        ifc.flush = 1'b1;
        step("stall_flush", zero_e);
        ifc.stall = 1'b0; ifc.flush = 1'b0;
        set_wb(1'b0, 5'd0, 64'd0);

        // load of invalid bundle -> bubble
        set_instr(64'h40, 64'd6, 64'd7, 64'd0, 5'd1, 5'd2, 5'd3, 4'h0, 2'b10, C_R);
        ifc.id_valid = 1'b0;
        step("id_invalid", zero_e);

        // and
        set_instr(64'h0, 64'hF0, 64'h3C, 64'd0, 5'd22, 5'd23, 5'd24, 4'h7, 2'b10, C_R);
        step("and", mk(1'b1, 64'h30, 64'h3C, 5'd24, 4'b0001, 1'b0, 64'd0));

        // reset mid-stream
        reset = 1'b1;
        set_instr(64'h80, 64'd1, 64'd1, 64'd8, 5'd1, 5'd2, 5'd3, 4'h0, 2'b10, C_R);
        step("reset_mid", zero_e);
        reset = 1'b0;

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
